disp_scan_ctrl: RTL and testbench

Sequencing controller for the 8-digit seven-segment display path. It latches a 32-bit value on a load strobe and converts it to eight display digits: hex digits directly, or decimal digits through a sequential double-dabble converter with one shift per clock. It then drives the digit-scan signals (`dig`, `pos`, `point`, `off`) into the existing digit decoder/pattern logic. It replaces the free-running divider plus combinational `%`/`/` digit selection with a single-clock, resettable scheduler that applies leading-zero blanking.

---
 rtl/disp_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Eight-digit seven-segment scan controller: latches a value, converts it to hex or
// decimal digits (double-dabble, one shift per clock) and time-multiplexes the digits.
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 150000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        mod,
    input  logic [31:0] data,
    input  logic [7:0]  point_mask,
    input  logic        blank,
    output logic        busy,
    output logic [3:0]  dig,
    output logic [2:0]  pos,
    output logic        point,
    output logic        off
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam int unsigned          SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]        SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [1:0]    state_q,  state_d;
    logic [4:0]    iter_q,   iter_d;
    logic [39:0]   bcd_q,    bcd_d;
    logic [31:0]   bin_q,    bin_d;
    logic          hex_q,    hex_d;
    logic [31:0]   data_q,   data_d;
    logic [7:0]    pcap_q,   pcap_d;
    logic [31:0]   disp_q,   disp_d;
    logic [7:0]    pmask_q,  pmask_d;
    logic [SW-1:0] scan_q,   scan_d;
    logic [2:0]    pos_q,    pos_d;

    logic [39:0]   bcd_adj;
    logic [39:0]   bcd_shift;
    logic [31:0]   bin_shift;
    logic          dd_overflow_unused;

    function automatic logic [39:0] dd_adjust(input logic [39:0] b);
        logic [39:0] r;
        r = b;
        for (int unsigned n = 0; n < 10; n++) begin
            if (b[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = b[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // One double-dabble step: correct nibbles, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = dd_adjust(bcd_q);
        {dd_overflow_unused, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        hex_d   = hex_q;
        data_d  = data_q;
        pcap_d  = pcap_q;
        disp_d  = disp_q;
        pmask_d = pmask_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    hex_d  = mod;
                    data_d = data;
                    pcap_d = point_mask;
                    if (mod) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_CONV;
                        iter_d  = '0;
                        bcd_d   = '0;
                        bin_d   = data;
                    end
                end
            end
            S_CONV: begin
                bcd_d  = bcd_shift;
                bin_d  = bin_shift;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // BCD digits 8 and 9 are dropped: decimal display is value mod 10^8.
                disp_d  = hex_q ? data_q : bcd_q[31:0];
                pmask_d = pcap_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        pos_d  = pos_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            pos_d  = pos_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            hex_q   <= 1'b0;
            data_q  <= '0;
            pcap_q  <= '0;
            disp_q  <= '0;
            pmask_q <= '0;
            scan_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            hex_q   <= hex_d;
            data_q  <= data_d;
            pcap_q  <= pcap_d;
            disp_q  <= disp_d;
            pmask_q <= pmask_d;
            scan_q  <= scan_d;
            pos_q   <= pos_d;
        end
    end

    logic [3:0] digit [8];
    logic [7:0] upper_zero;

    // upper_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            digit[i] = disp_q[4*i +: 4];
        end
        upper_zero[7] = (digit[7] == 4'd0);
        for (int unsigned i = 0; i < 7; i++) begin
            upper_zero[6-i] = upper_zero[7-i] & (digit[6-i] == 4'd0);
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign pos   = pos_q;
    assign dig   = digit[pos_q];
    assign point = pmask_q[pos_q];
    assign off   = blank | (LZ_BLANK & (pos_q != 3'd0) & upper_zero[pos_q]);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed and random loads checked against an arithmetic
// model of the displayed digits, scan position and blanking.
module tb_disp_scan_ctrl;

    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        mod = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  point_mask = '0;
    logic        blank = 1'b0;
    logic        busy;
    logic [3:0]  dig;
    logic [2:0]  pos;
    logic        point;
    logic        off;

    disp_scan_ctrl #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .mod(mod), .data(data),
        .point_mask(point_mask), .blank(blank), .busy(busy), .dig(dig),
        .pos(pos), .point(point), .off(off)
    );

    always #5 clk = ~clk;

    int unsigned npass = 0;
    int unsigned ntot  = 0;
    int unsigned mcnt  = 0;
    logic [3:0]  mdig [8];
    logic [7:0]  mpt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Edges since reset release determine the scan position.
    task automatic tick();
        @(posedge clk);
        if (rst) mcnt = 0;
        else mcnt++;
        #1;
    endtask

    function automatic int unsigned mpos();
        return (mcnt / SD) % 8;
    endfunction

    function automatic logic moff(input int unsigned p);
        logic lead;
        lead = (p != 0);
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(p) && mdig[j] != 4'd0) lead = 1'b0;
        end
        return blank | lead;
    endfunction

    task automatic check_outputs(input string tag);
        int unsigned p;
        p = mpos();
        chk({tag, "_pos"}, {29'd0, pos}, p);
        chk({tag, "_dig"}, {28'd0, dig}, {28'd0, mdig[p]});
        chk({tag, "_point"}, {31'd0, point}, {31'd0, mpt[p]});
        chk({tag, "_off"}, {31'd0, off}, {31'd0, moff(p)});
    endtask

    task automatic set_model(input logic m, input logic [31:0] d, input logic [7:0] pm);
        longint unsigned v, pw;
        v  = longint'(d) % 64'd100000000;
        pw = 1;
        for (int i = 0; i < 8; i++) begin
            if (m) mdig[i] = 4'((d >> (4 * i)) & 32'hF);
            else mdig[i] = 4'((v / pw) % 10);
            pw = pw * 10;
        end
        mpt = pm;
    endtask

    task automatic do_load(input logic m, input logic [31:0] d, input logic [7:0] pm,
                           input bit inject);
        int unsigned cnt;
        load = 1'b1; mod = m; data = d; point_mask = pm;
        tick();
        load = 1'b0; mod = 1'($urandom); data = $urandom; point_mask = 8'($urandom);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            check_outputs("hold");
            if (inject && cnt == 5) begin
                load = 1'b1; mod = 1'b1; data = 32'hDEADBEEF; point_mask = 8'hFF;
            end
            tick();
            load = 1'b0;
        end
        chk("busy_len", cnt, m ? 32'd1 : 32'd33);
        set_model(m, d, pm);
        check_outputs("new");
    endtask

    task automatic sweep(input int unsigned n);
        repeat (n) begin
            tick();
            check_outputs("scan");
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mdig[i] = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        check_outputs("reset");

        // Decimal conversion, then overflow truncation
        do_load(1'b0, 32'd12345678, 8'h00, 1'b0);
        sweep(9 * SD);
        do_load(1'b0, 32'hFFFFFFFF, 8'h00, 1'b0);
        sweep(8 * SD);

        // Hex with leading-zero blanking, and zero value
        do_load(1'b1, 32'h00000A05, 8'h01, 1'b0);
        sweep(8 * SD);
        do_load(1'b1, 32'h00000000, 8'h00, 1'b0);
        sweep(8 * SD);

        // Load while busy is ignored
        do_load(1'b0, 32'd100, 8'h00, 1'b1);
        sweep(8 * SD);

        // Blank acts immediately, scan keeps advancing
        sweep(2);
        blank = 1'b1;
        #1;
        chk("blank_imm", {31'd0, off}, 32'd1);
        sweep(3 * SD);
        blank = 1'b0;
        #1;
        check_outputs("unblank");

        // Reset in the middle of a conversion
        load = 1'b1; mod = 1'b0; data = 32'd87654321; point_mask = 8'hAA;
        tick();
        load = 1'b0;
        repeat (10) tick();
        chk("conv_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_model(1'b1, 32'd0, 8'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        check_outputs("rst");
        sweep(3);
        do_load(1'b1, 32'h12, 8'h00, 1'b0);
        sweep(8 * SD);

        // Random loads with occasional blanking
        repeat (10) begin
            blank = ($urandom_range(0, 3) == 0);
            do_load(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31),
                    8'($urandom), 1'b0);
            sweep($urandom_range(SD, 8 * SD));
        end
        blank = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
